// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble binary-to-packed-BCD converter for the seven-segment display stage.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with the 4'hF blank code.
module bin_to_bcd_display #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int SR_W  = BIN_W + 4*DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_next;
  logic [SR_W-1:0]     sr;
  logic [SR_W-1:0]     sr_adj;
  logic [SR_W-1:0]     sr_shift;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_q;
  logic [4*DIGITS-1:0] result;

  assign busy = (state != IDLE);

  always_comb begin
    sr_adj = sr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sr[BIN_W + 4*i +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
    end
    sr_shift = sr_adj << 1;
  end

  // Saturation takes priority; blanking only ever applies to an exact conversion.
  always_comb begin
    result = sr[SR_W-1:BIN_W];
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic leading;
      leading = 1'b1;
      for (int unsigned i = DIGITS-1; i > 0; i--) begin
        if (leading && (sr[BIN_W + 4*i +: 4] == 4'h0))
          result[4*i +: 4] = 4'hF;
        else
          leading = 1'b0;
      end
    end
`endif
    if (ovf_q) result = {DIGITS{4'h9}};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= SR_W'(bin_in);
            cnt   <= CNT_W'(BIN_W);
            ovf_q <= (64'(bin_in) > MAX_VAL);
          end
        end
        SHIFT: begin
          sr  <= sr_shift;
          cnt <= cnt - CNT_W'(1);
        end
        DONE: begin
          bcd_out  <= result;
          overflow <= ovf_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
